// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared state encoding, default timing and width helper for the clock blocks
package clock_pkg;

   // Top-level mode of the clock: counting time or editing it
   typedef enum logic {
      ST_RUN = 1'b0,
      ST_SET = 1'b1
   } state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_CLK_PER_MIN     = 6000;
   localparam int DEF_REPEAT_DELAY    = 500;
   localparam int DEF_REPEAT_PERIOD   = 100;
   localparam int DEF_SET_TIMEOUT     = 10000;

   // Width of a counter that runs 0..n-1, never narrower than one bit
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser, debouncer and registered press pulse
module btn_debounce
   import clock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam int             CW       = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level_q;
   logic [CW-1:0] cnt;

   // Two-flop synchroniser for the asynchronous button input
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   // Level only follows the synced input after it has disagreed for DEBOUNCE_CYCLES cycles in a row
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (sync2 != level) begin
         if (cnt == CNT_LAST) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else begin
         cnt <= '0;
      end
   end

   // One-cycle pulse on each rising edge of the debounced level
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         level_q <= 1'b0;
         press   <= 1'b0;
      end else begin
         level_q <= level;
         press   <= level & ~level_q;
      end
   end

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - RUN/SET mode control, minute prescaler and add strobes; optional TIME_SET_AUTO_REPEAT_EN
module time_set_ctrl
   import clock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CLK_PER_MIN     = DEF_CLK_PER_MIN,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter int SET_TIMEOUT     = DEF_SET_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_mode,
   input  logic btn_inc,
   output logic add,
   output logic minute,
   output logic modify,
   output logic blink
);

   localparam int             PW        = cnt_w(CLK_PER_MIN);
   localparam int             TW        = cnt_w(SET_TIMEOUT);
   localparam int             BW        = cnt_w(REPEAT_PERIOD);
   localparam logic [PW-1:0]  PRE_LAST  = PW'(CLK_PER_MIN - 1);
   localparam logic [TW-1:0]  TMO_LAST  = TW'(SET_TIMEOUT - 1);
   localparam logic [BW-1:0]  BLK_LAST  = BW'(REPEAT_PERIOD - 1);

   logic          unused_mode_level;
   logic          mode_press;
   logic          inc_level;
   logic          inc_press;

   state_t        state;
   state_t        state_next;
   logic          add_next;
   logic          minute_next;
   logic          stay_set;
   logic          stay_run;

   logic [PW-1:0] pre;
   logic [TW-1:0] tmo;
   logic [BW-1:0] blk_cnt;
   logic          rep_fire;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_mode_btn (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_mode),
      .level   (unused_mode_level),
      .press   (mode_press)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_inc_btn (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_inc),
      .level   (inc_level),
      .press   (inc_press)
   );

   assign stay_set = (state == ST_SET) && (state_next == ST_SET);
   assign stay_run = (state == ST_RUN) && (state_next == ST_RUN);

   // Mode transitions and strobe decisions; a mode press always beats an inc press or a prescaler wrap
   always_comb begin
      state_next  = state;
      add_next    = 1'b0;
      minute_next = 1'b0;
      case (state)
         ST_RUN: begin
            if (mode_press) begin
               state_next = ST_SET;
            end else if (pre == PRE_LAST) begin
               minute_next = 1'b1;
            end
         end
         ST_SET: begin
            if (mode_press || (tmo == TMO_LAST)) begin
               state_next = ST_RUN;
            end else if (inc_press || rep_fire) begin
               add_next = 1'b1;
            end
         end
      endcase
   end

   // Mode state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_RUN;
      end else begin
         state <= state_next;
      end
   end

   // Registered strobes and mode level
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         add    <= 1'b0;
         minute <= 1'b0;
         modify <= 1'b0;
      end else begin
         add    <= add_next;
         minute <= minute_next;
         modify <= (state_next == ST_SET);
      end
   end

   // Minute prescaler runs only while staying in RUN, so an edit restarts the minute from zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre <= '0;
      end else if (stay_run) begin
         pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
      end else begin
         pre <= '0;
      end
   end

   // Idle timer in SET; any increment activity counts as user activity
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo <= '0;
      end else if (stay_set) begin
         tmo <= (inc_press || rep_fire) ? '0 : tmo + 1'b1;
      end else begin
         tmo <= '0;
      end
   end

   // Display blanking square wave in SET, forced low in RUN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blk_cnt <= '0;
         blink   <= 1'b0;
      end else if (stay_set) begin
         if (blk_cnt == BLK_LAST) begin
            blk_cnt <= '0;
            blink   <= ~blink;
         end else begin
            blk_cnt <= blk_cnt + 1'b1;
         end
      end else begin
         blk_cnt <= '0;
         blink   <= 1'b0;
      end
   end

`ifdef TIME_SET_AUTO_REPEAT_EN
   localparam int             RW      = (REPEAT_DELAY > REPEAT_PERIOD) ? cnt_w(REPEAT_DELAY)
                                                                       : cnt_w(REPEAT_PERIOD);
   localparam logic [RW-1:0]  RD_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0]  RP_LAST = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0] rep_cnt;
   logic          rep_active;
   logic          rep_first_done;

   assign rep_fire = rep_active && (state == ST_SET) && inc_level &&
                     (rep_first_done ? (rep_cnt == RP_LAST) : (rep_cnt == RD_LAST));

   // Auto-repeat timer armed by a press in SET, disarmed on release or leaving SET
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rep_cnt        <= '0;
         rep_active     <= 1'b0;
         rep_first_done <= 1'b0;
      end else if (!stay_set || !inc_level) begin
         rep_cnt        <= '0;
         rep_active     <= 1'b0;
         rep_first_done <= 1'b0;
      end else if (inc_press) begin
         rep_cnt        <= '0;
         rep_active     <= 1'b1;
         rep_first_done <= 1'b0;
      end else if (rep_active) begin
         if (rep_fire) begin
            rep_cnt        <= '0;
            rep_first_done <= 1'b1;
         end else begin
            rep_cnt <= rep_cnt + 1'b1;
         end
      end
   end
`else
   localparam int unused_repeat_delay = REPEAT_DELAY;
   logic          unused_inc_level;

   assign rep_fire         = 1'b0;
   assign unused_inc_level = inc_level;
`endif

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - randomized self-checking bench for time_set_ctrl
module tb_time_set_ctrl;

   localparam int D   = 4;
   localparam int CPM = 20;
   localparam int RD  = 10;
   localparam int RP  = 5;
   localparam int TO  = 100;
   // raw edge -> visible strobe/mode change: sync 2 + debounce D + press 1 + output register 1
   localparam int LAT = 2 + D + 1 + 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic btn_mode = 1'b0;
   logic btn_inc = 1'b0;
   logic add, minute, modify, blink;

   int cyc = 0;
   int errors = 0;
   int checks = 0;
   int add_q[$];
   int min_q[$];
   int both_hi = 0;

   time_set_ctrl #(
      .DEBOUNCE_CYCLES (D),
      .CLK_PER_MIN     (CPM),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP),
      .SET_TIMEOUT     (TO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_mode (btn_mode),
      .btn_inc  (btn_inc),
      .add      (add),
      .minute   (minute),
      .modify   (modify),
      .blink    (blink)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (add === 1'b1) add_q.push_back(cyc);
      if (minute === 1'b1) min_q.push_back(cyc);
      if (add === 1'b1 && minute === 1'b1) both_hi++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      add_q.delete();
      min_q.delete();
   endtask

   task automatic press_mode(input int hold);
      btn_mode = 1'b1;
      tick(hold);
      btn_mode = 1'b0;
      tick(D + 6);
   endtask

   function automatic int count_between(input int lo, input int hi, input int q[$]);
      int n = 0;
      foreach (q[i]) if (q[i] > lo && q[i] <= hi) n++;
      return n;
   endfunction

   task automatic test_reset();
      int base;
      int seen_hi = 0;
      int got;
      rst = 1'b0;
      tick(3);
      #2;
      checks++; if (add !== 1'b0) begin errors++; $display("FAIL reset_add got=%b exp=0", add); end
      checks++; if (minute !== 1'b0) begin errors++; $display("FAIL reset_minute got=%b exp=0", minute); end
      checks++; if (modify !== 1'b0) begin errors++; $display("FAIL reset_modify got=%b exp=0", modify); end
      checks++; if (blink !== 1'b0) begin errors++; $display("FAIL reset_blink got=%b exp=0", blink); end
      @(posedge clk); #1;
      rst = 1'b1;
      base = cyc;
      clear_mon();
      for (int i = 0; i < 65; i++) begin
         tick(1);
         if (modify !== 1'b0 || blink !== 1'b0) seen_hi++;
      end
      checks++; if (min_q.size() != 3) begin errors++; $display("FAIL idle_minute_count got=%0d exp=3", min_q.size()); end
      for (int k = 0; k < 3; k++) begin
         got = (k < min_q.size()) ? min_q[k] : -1;
         checks++; if (got != base + CPM * (k + 1)) begin errors++; $display("FAIL idle_minute_time k=%0d got=%0d exp=%0d", k, got, base + CPM * (k + 1)); end
      end
      checks++; if (add_q.size() != 0) begin errors++; $display("FAIL idle_add got=%0d exp=0", add_q.size()); end
      checks++; if (seen_hi != 0) begin errors++; $display("FAIL idle_modify_blink got=%0d exp=0", seen_hi); end
   endtask

   task automatic test_mode();
      int g = $urandom_range(1, D - 1);
      int m;
      int rise = -1;
      int toggles = 0;
      logic prev;
      btn_mode = 1'b1;
      tick(g);
      btn_mode = 1'b0;
      tick(20);
      checks++; if (modify !== 1'b0) begin errors++; $display("FAIL glitch_len%0d got=%b exp=0", g, modify); end
      clear_mon();
      btn_mode = 1'b1;
      m = cyc;
      for (int i = 0; i < 30; i++) begin
         tick(1);
         if (modify === 1'b1 && rise < 0) rise = cyc;
         if (i == 9) btn_mode = 1'b0;
      end
      tick(10);
      checks++; if (rise != m + LAT) begin errors++; $display("FAIL mode_enter_latency got=%0d exp=%0d", rise - m, LAT); end
      checks++; if (count_between(rise, cyc, min_q) != 0) begin errors++; $display("FAIL minute_in_set got=%0d exp=0", count_between(rise, cyc, min_q)); end
      prev = blink;
      for (int i = 0; i < 4 * RP; i++) begin
         tick(1);
         if (blink !== prev) toggles++;
         prev = blink;
      end
      checks++; if (toggles != 4) begin errors++; $display("FAIL blink_toggles got=%0d exp=4", toggles); end
   endtask

   task automatic test_inc_set();
      int e[3];
      int h;
      int got;
      clear_mon();
      for (int i = 0; i < 3; i++) begin
         h = $urandom_range(D + 1, 8);
         e[i] = cyc;
         btn_inc = 1'b1;
         tick(h);
         btn_inc = 1'b0;
         tick(20 - h);
      end
      checks++; if (add_q.size() != 3) begin errors++; $display("FAIL set_add_count got=%0d exp=3", add_q.size()); end
      for (int i = 0; i < 3; i++) begin
         got = (i < add_q.size()) ? add_q[i] : -1;
         checks++; if (got != e[i] + LAT) begin errors++; $display("FAIL set_add_time i=%0d got=%0d exp=%0d", i, got, e[i] + LAT); end
      end
      press_mode(10);
      checks++; if (modify !== 1'b0) begin errors++; $display("FAIL exit_set got=%b exp=0", modify); end
   endtask

   task automatic test_inc_run();
      int h;
      clear_mon();
      for (int i = 0; i < 3; i++) begin
         h = $urandom_range(D + 1, 8);
         btn_inc = 1'b1;
         tick(h);
         btn_inc = 1'b0;
         tick(20 - h);
      end
      checks++; if (add_q.size() != 0) begin errors++; $display("FAIL run_add got=%0d exp=0", add_q.size()); end
      checks++; if (modify !== 1'b0) begin errors++; $display("FAIL run_modify got=%b exp=0", modify); end
   endtask

   task automatic test_auto_repeat();
      int m;
      int r;
      int p;
      int exp_q[$];
      int got;
      press_mode(10);
      clear_mon();
      m = cyc;
      btn_inc = 1'b1;
      tick(40);
      btn_inc = 1'b0;
      r = cyc;
      tick(D + 10);
      p = m + LAT;
      exp_q.push_back(p);
`ifdef TIME_SET_AUTO_REPEAT_EN
      // debounced inc is still seen high on the edge r+D+2, low afterwards
      for (int t = p + RD; t <= r + D + 2; t += RP) exp_q.push_back(t);
`endif
      checks++; if (add_q.size() != exp_q.size()) begin errors++; $display("FAIL hold_add_count got=%0d exp=%0d", add_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         got = (i < add_q.size()) ? add_q[i] : -1;
         checks++; if (got != exp_q[i]) begin errors++; $display("FAIL hold_add_time i=%0d got=%0d exp=%0d", i, got, exp_q[i]); end
      end
      press_mode(10);
      checks++; if (modify !== 1'b0) begin errors++; $display("FAIL hold_exit got=%b exp=0", modify); end
   endtask

   task automatic test_timeout();
      int rise = -1;
      int fall = -1;
      int first = -1;
      clear_mon();
      btn_mode = 1'b1;
      for (int i = 0; i < 30 && rise < 0; i++) begin
         tick(1);
         if (modify === 1'b1) rise = cyc;
      end
      tick(10 - (LAT));
      btn_mode = 1'b0;
      for (int i = 0; i < 150 && fall < 0; i++) begin
         tick(1);
         if (modify === 1'b0) fall = cyc;
      end
      checks++; if (rise < 0 || fall < 0 || fall - rise != TO) begin errors++; $display("FAIL timeout_len got=%0d exp=%0d", fall - rise, TO); end
      checks++; if (count_between(rise, fall, min_q) != 0) begin errors++; $display("FAIL timeout_minute_in_set got=%0d exp=0", count_between(rise, fall, min_q)); end
      tick(CPM + 5);
      foreach (min_q[i]) if (first < 0 && min_q[i] > fall) first = min_q[i];
      checks++; if (first != fall + CPM) begin errors++; $display("FAIL first_minute_after_edit got=%0d exp=%0d", first - fall, CPM); end
   endtask

   task automatic test_simultaneous();
      int m;
      int fall = -1;
      int h = $urandom_range(D + 1, 9);
      press_mode(10);
      clear_mon();
      m = cyc;
      btn_mode = 1'b1;
      btn_inc = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick(1);
         if (modify === 1'b0 && fall < 0) fall = cyc;
         if (i == h - 1) begin
            btn_mode = 1'b0;
            btn_inc = 1'b0;
         end
      end
      checks++; if (fall != m + LAT) begin errors++; $display("FAIL simul_exit_latency got=%0d exp=%0d", fall - m, LAT); end
      checks++; if (add_q.size() != 0) begin errors++; $display("FAIL simul_add got=%0d exp=0", add_q.size()); end
   endtask

   task automatic test_reset_mid();
      int base;
      int got;
      press_mode(10);
      btn_inc = 1'b1;
      tick($urandom_range(3, 12));
      #3 rst = 1'b0;
      #1;
      checks++; if ({add, minute, modify, blink} !== 4'b0000) begin errors++; $display("FAIL midreset_outputs got=%b exp=0000", {add, minute, modify, blink}); end
      @(posedge clk); #1;
      rst = 1'b1;
      base = cyc;
      clear_mon();
      tick(CPM + 5);
      got = (min_q.size() > 0) ? min_q[0] : -1;
      checks++; if (got != base + CPM) begin errors++; $display("FAIL midreset_run_minute got=%0d exp=%0d", got, base + CPM); end
      checks++; if (add_q.size() != 0) begin errors++; $display("FAIL midreset_add got=%0d exp=0", add_q.size()); end
      checks++; if (modify !== 1'b0) begin errors++; $display("FAIL midreset_modify got=%b exp=0", modify); end
      btn_inc = 1'b0;
      tick(D + 6);
   endtask

   initial begin
      test_reset();
      test_mode();
      test_inc_set();
      test_inc_run();
      test_auto_repeat();
      test_timeout();
      test_simultaneous();
      test_reset_mid();
      checks++; if (both_hi != 0) begin errors++; $display("FAIL add_minute_overlap got=%0d exp=0", both_hi); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
